// File: rtl/bool_unit.sv
// bool_unit: bitwise boolean function unit for the BETA ALU.
// BFN is a 4-entry truth table. Each result bit is chosen from BFN by the
// operand bit pair {B[i], A[i]}, with B as the index MSB.
// Y is purely combinational and feeds the ALU result mux.
// Y_REG and ZERO_REG are registered copies for pipelined or debug consumers.
module bool_unit #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [3:0]       BFN,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Y,
   output logic [WIDTH-1:0] Y_REG,
   output logic             ZERO_REG
);

   logic [WIDTH-1:0] y_reg_d;
   logic [WIDTH-1:0] y_reg_q;
   logic             zero_reg_d;
   logic             zero_reg_q;

   // Every bit has its own 4:1 truth-table lookup. There is no carry or other
   // cross-bit dependence, so each bit stays an independent LUT.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [1:0] sel;

      // Form the truth-table index for this bit. B is the MSB and A is the LSB.
      always_comb begin
         sel = {B[gi], A[gi]};
      end

      // Look up the result bit. All 16 BFN codes are legal, so no guard is needed.
      always_comb begin
         Y[gi] = BFN[sel];
      end
   end

   // Compute the next register values from the live combinational result.
   always_comb begin
      y_reg_d    = Y;
      zero_reg_d = (Y == '0);
   end

   // Capture the result and zero flag on each rising edge.
   // Reset clears the registers immediately, without waiting for a clock edge.
   // The reset value of the zero flag is 1 so that it agrees with the cleared result.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         y_reg_q    <= '0;
         zero_reg_q <= 1'b1;
      end else begin
         y_reg_q    <= y_reg_d;
         zero_reg_q <= zero_reg_d;
      end
   end

   assign Y_REG    = y_reg_q;
   assign ZERO_REG = zero_reg_q;

endmodule

// File: tb/tb_bool_unit.sv
// Directed testbench for bool_unit.
// It covers the truth-table sweep, the named operations, the combinational
// and registered paths, asynchronous reset, and the edge bit lanes.
module tb_bool_unit;

   logic        CLK;
   logic        RESET;
   logic [3:0]  BFN;
   logic [31:0] A;
   logic [31:0] B;
   logic [31:0] Y;
   logic [31:0] Y_REG;
   logic        ZERO_REG;

   int checks_cnt;
   int fail_cnt;

   bool_unit #(.WIDTH(32)) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .BFN      (BFN),
      .A        (A),
      .B        (B),
      .Y        (Y),
      .Y_REG    (Y_REG),
      .ZERO_REG (ZERO_REG)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_cnt++;
      if (obs !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", tag, obs, exp);
      end else begin
         $display("check %s: 0x%08h ok", tag, obs);
      end
   endtask

   // Hand-computed expected results for the common stimulus A=FF00FF00, B=FFFF0000.
   logic [3:0]  op_bfn [10] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0111,
                                4'b1111, 4'b1010, 4'b1100, 4'b0110, 4'b1110};
   logic [31:0] op_exp [10] = '{32'h000000FF, 32'h0000FF00, 32'h00FF0000, 32'hFF000000,
                                32'h00FFFFFF, 32'hFFFFFFFF, 32'hFF00FF00, 32'hFFFF0000,
                                32'h00FFFF00, 32'hFFFFFF00};

   initial begin
      logic [31:0] lane_exp;
      checks_cnt = 0;
      fail_cnt   = 0;
      RESET = 1'b1;
      BFN   = 4'b0000;
      A     = 32'hFF00FF00;
      B     = 32'hFFFF0000;

      // Check the reset state. Y must still track its inputs while RESET is high.
      #1;
      check("reset_y_reg", Y_REG, 32'h0);
      check("reset_zero", {31'b0, ZERO_REG}, 32'h1);
      check("reset_y_live", Y, 32'h0);

      // Sweep all 16 codes. Byte lane k of Y must be FF when BFN[k] is 1.
      for (int f = 0; f < 16; f++) begin
         BFN = f[3:0];
         #1;
         lane_exp = {{8{f[3]}}, {8{f[2]}}, {8{f[1]}}, {8{f[0]}}};
         check($sformatf("sweep_bfn%0d", f), Y, lane_exp);
      end

      // Check the named operations and spot values from the hand table.
      for (int i = 0; i < 10; i++) begin
         BFN = op_bfn[i];
         #1;
         check($sformatf("op_%b", op_bfn[i]), Y, op_exp[i]);
      end

      // Check the edge bit lanes: AND with only bit 31 common to both operands.
      A = 32'h80000001; B = 32'h80000000; BFN = 4'b1000;
      #1;
      check("and_edges", Y, 32'h80000000);

      // Check the edge bit lanes: XNOR of the same operands.
      BFN = 4'b1001;
      #1;
      check("xnor_edges", Y, 32'hFFFFFFFE);

      // Release reset between edges, then capture a zero result.
      A = 32'hFF00FF00; B = 32'hFFFF0000;
      @(negedge CLK);
      RESET = 1'b0;
      BFN   = 4'b0000;
      @(posedge CLK); #1;
      check("reg_zero_y", Y_REG, 32'h0);
      check("reg_zero_flag", {31'b0, ZERO_REG}, 32'h1);

      // Combinational path: Y must move between edges while Y_REG holds its value.
      @(negedge CLK);
      BFN = 4'b1111;
      #1;
      check("comb_y", Y, 32'hFFFFFFFF);
      check("comb_y_reg_hold", Y_REG, 32'h0);
      @(posedge CLK); #1;
      check("reg_ones_y", Y_REG, 32'hFFFFFFFF);
      check("reg_ones_flag", {31'b0, ZERO_REG}, 32'h0);

      // Asynchronous reset mid-cycle clears the registers without a clock edge.
      @(negedge CLK);
      #2;
      RESET = 1'b1;
      #1;
      check("async_y_reg", Y_REG, 32'h0);
      check("async_zero", {31'b0, ZERO_REG}, 32'h1);
      check("async_y_live", Y, 32'hFFFFFFFF);

      // The first edge after reset is released captures the current Y.
      @(negedge CLK);
      RESET = 1'b0;
      BFN   = 4'b1010;
      @(posedge CLK); #1;
      check("post_reset_y_reg", Y_REG, 32'hFF00FF00);
      check("post_reset_flag", {31'b0, ZERO_REG}, 32'h0);

      // A nonzero code can still give a zero result, and the flag must follow it.
      @(negedge CLK);
      A = 32'h0000FFFF; B = 32'hFFFF0000; BFN = 4'b1000;
      @(posedge CLK); #1;
      check("and_disjoint_y_reg", Y_REG, 32'h0);
      check("and_disjoint_flag", {31'b0, ZERO_REG}, 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
      $finish;
   end

endmodule
